// File: rtl/gpu_host_link.sv
`default_nettype none
//==============================================================================
// Module   : gpu_host_link
// Brief    : Host-side initiator of the GPU-controller command protocol.
//            Accepts COPY_TO_GPU / COPY_FROM_GPU requests and issues them
//            as instr, addr, count and then a data phase. Uploads are
//            buffered first; downloads are forwarded with an ack timeout.
// Revision : 1.0 - initial release
//==============================================================================
module gpu_host_link #(
    parameter int BUF_WORDS   = 16,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_count,
    input  logic        wr_valid,
    input  logic [31:0] wr_data,
    output logic        wr_ready,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        done,
    output logic        err,
    output logic [31:0] gpu_instr,
    output logic [31:0] gpu_data,
    input  logic [31:0] gpu_out_data,
    input  logic        gpu_out_ack
);

    // Pointers carry one extra bit so a full buffer is distinguishable.
    localparam int c_PTR_W = $clog2(BUF_WORDS) + 1;
    localparam int c_IDX_W = c_PTR_W - 1;
    localparam int c_TMO_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [1:0]         c_OP_TO     = 2'd1;
    localparam logic [1:0]         c_OP_FROM   = 2'd2;
    localparam logic [31:0]        c_MAX_BYTES = 32'(4 * BUF_WORDS);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST  = c_TMO_W'(ACK_TIMEOUT - 1);

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_FILL       = 3'd1;
    localparam logic [2:0] c_SEND_INSTR = 3'd2;
    localparam logic [2:0] c_SEND_ADDR  = 3'd3;
    localparam logic [2:0] c_SEND_COUNT = 3'd4;
    localparam logic [2:0] c_SEND_DATA  = 3'd5;
    localparam logic [2:0] c_RECV_DATA  = 3'd6;

    logic [2:0]         r_state;
    logic [1:0]         r_op;
    logic [31:0]        r_addr;
    logic [31:0]        r_count;
    logic [31:0]        r_nwords;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [31:0]        r_rx_cnt;
    logic [c_TMO_W-1:0] r_tmo;
    logic               r_req_ready;
    logic               r_rd_valid;
    logic [31:0]        r_rd_data;
    logic               r_done;
    logic               r_err;
    logic [31:0]        r_buf [BUF_WORDS];

    logic [2:0]         w_state_nxt;
    logic               w_done_nxt;
    logic               w_err_nxt;
    logic               w_accept;
    logic               w_req_bad;
    logic               w_wr_ready;
    logic               w_wr_fire;
    logic               w_wr_last;
    logic               w_rd_last;
    logic               w_rx_last;

    assign w_accept   = r_req_ready & req_valid;
    assign w_req_bad  = ((req_op != c_OP_TO) && (req_op != c_OP_FROM)) ||
                        (req_count == 32'd0) ||
                        (req_count[1:0] != 2'b00) ||
                        ((req_op == c_OP_TO) && (req_count > c_MAX_BYTES));
    assign w_wr_ready = (r_state == c_FILL) && (32'(r_wr_ptr) < r_nwords);
    assign w_wr_fire  = w_wr_ready & wr_valid;
    assign w_wr_last  = (32'(r_wr_ptr) == (r_nwords - 32'd1));
    assign w_rd_last  = (32'(r_rd_ptr) == (r_nwords - 32'd1));
    assign w_rx_last  = ((r_rx_cnt + 32'd1) == r_nwords);

    // Next-state and completion/error pulse decode.
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    if (w_req_bad) begin
                        w_err_nxt = 1'b1;
                    end else if (req_op == c_OP_TO) begin
                        w_state_nxt = c_FILL;
                    end else begin
                        w_state_nxt = c_SEND_INSTR;
                    end
                end
            end
            c_FILL: begin
                if (w_wr_fire && w_wr_last) begin
                    w_state_nxt = c_SEND_INSTR;
                end
            end
            c_SEND_INSTR: w_state_nxt = c_SEND_ADDR;
            c_SEND_ADDR:  w_state_nxt = c_SEND_COUNT;
            c_SEND_COUNT: w_state_nxt = (r_op == c_OP_TO) ? c_SEND_DATA : c_RECV_DATA;
            c_SEND_DATA: begin
                if (w_rd_last) begin
                    w_state_nxt = c_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            c_RECV_DATA: begin
                // An ack in the timeout cycle still counts as in time.
                if (gpu_out_ack) begin
                    if (w_rx_last) begin
                        w_state_nxt = c_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else if (r_tmo == c_TMO_LAST) begin
                    w_state_nxt = c_IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Control state, command latches, pointers and registered pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_op        <= 2'd0;
            r_addr      <= 32'd0;
            r_count     <= 32'd0;
            r_nwords    <= 32'd0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rx_cnt    <= 32'd0;
            r_tmo       <= '0;
            r_req_ready <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= 32'd0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            // Low on the done/err cycle so commands are separated by a NOP.
            r_req_ready <= (w_state_nxt == c_IDLE) && !w_done_nxt && !w_err_nxt;
            r_rd_valid  <= 1'b0;

            if ((r_state == c_IDLE) && w_accept) begin
                r_op     <= req_op;
                r_addr   <= req_addr;
                r_count  <= req_count;
                r_nwords <= req_count >> 2;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_rx_cnt <= 32'd0;
            end

            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (r_state == c_SEND_DATA) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            if (r_state == c_SEND_COUNT) begin
                r_tmo <= c_TMO_W'(1);
            end

            if (r_state == c_RECV_DATA) begin
                if (gpu_out_ack) begin
                    r_rd_valid <= 1'b1;
                    r_rd_data  <= gpu_out_data;
                    r_rx_cnt   <= r_rx_cnt + 32'd1;
                    r_tmo      <= c_TMO_W'(1);
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end
        end
    end

    // Upload buffer storage; contents need no reset since pointers gate use.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_buf[r_wr_ptr[c_IDX_W-1:0]] <= wr_data;
        end
    end

    // Controller-side data wires: a word only in the phases that carry one.
    always_comb begin
        gpu_data = 32'd0;
        case (r_state)
            c_SEND_ADDR:  gpu_data = r_addr;
            c_SEND_COUNT: gpu_data = r_count;
            c_SEND_DATA:  gpu_data = r_buf[r_rd_ptr[c_IDX_W-1:0]];
            default:      gpu_data = 32'd0;
        endcase
    end

    assign gpu_instr = (r_state == c_SEND_INSTR) ? {30'd0, r_op} : 32'd0;
    assign req_ready = r_req_ready;
    assign wr_ready  = w_wr_ready;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gpu_host_link.sv
`default_nettype none
//==============================================================================
// Module   : tb_gpu_host_link
// Brief    : Self-checking bench for gpu_host_link: directed protocol cases
//            plus randomized commands checked against transaction-level
//            expectations derived from the command rules.
// Revision : 1.0 - initial release
//==============================================================================
module tb_gpu_host_link;

    localparam int BUF_WORDS   = 8;
    localparam int ACK_TIMEOUT = 40;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_count;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        done;
    logic        err;
    logic [31:0] gpu_instr;
    logic [31:0] gpu_data;
    logic [31:0] gpu_out_data;
    logic        gpu_out_ack;

    int n_chk;
    int n_fail;

    logic [31:0] wq[$];

    gpu_host_link #(
        .BUF_WORDS   (BUF_WORDS),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_count    (req_count),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .done         (done),
        .err          (err),
        .gpu_instr    (gpu_instr),
        .gpu_data     (gpu_data),
        .gpu_out_data (gpu_out_data),
        .gpu_out_ack  (gpu_out_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // done and err are mutually exclusive in every cycle.
    always @(negedge clk) begin
        chk("done_err_excl", 32'(done & err), 32'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] cnt);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_count = cnt;
        step();
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_addr  = 32'd0;
        req_count = 32'd0;
    endtask

    task automatic do_reject(input logic [1:0] op, input logic [31:0] cnt);
        issue(op, 32'h0000_1000, cnt);
        chk("rej_err", 32'(err), 32'd1);
        chk("rej_done", 32'(done), 32'd0);
        chk("rej_ready_low", 32'(req_ready), 32'd0);
        chk("rej_wr_ready", 32'(wr_ready), 32'd0);
        chk("rej_instr", gpu_instr, 32'd0);
        step();
        chk("rej_err_end", 32'(err), 32'd0);
        chk("rej_ready_back", 32'(req_ready), 32'd1);
        chk("rej_instr_after", gpu_instr, 32'd0);
    endtask

    // Upload of wq; abort_at >= 0 resets the DUT once that data word is on the wires.
    task automatic do_copy_to(input logic [31:0] addr, input int gap_pct, input int abort_at);
        int n;
        int idx;
        int budget;
        logic fire;
        n      = wq.size();
        idx    = 0;
        budget = 0;
        issue(2'd1, addr, 32'(4 * n));
        while (idx < n && budget < 2000) begin
            chk("to_fill_ready", 32'(wr_ready), 32'd1);
            chk("to_fill_instr", gpu_instr, 32'd0);
            if (wr_ready !== 1'b1) break;
            wr_valid = ($urandom_range(0, 99) >= gap_pct);
            wr_data  = wr_valid ? wq[idx] : $urandom;
            fire     = wr_valid & wr_ready;
            step();
            if (fire) idx++;
            budget++;
        end
        wr_valid = 1'b0;
        wr_data  = 32'd0;
        chk("to_fill_count", 32'(idx), 32'(n));
        chk("to_instr", gpu_instr, 32'd1);
        chk("to_instr_data", gpu_data, 32'd0);
        chk("to_wr_ready_off", 32'(wr_ready), 32'd0);
        step();
        chk("to_addr", gpu_data, addr);
        chk("to_addr_instr", gpu_instr, 32'd0);
        step();
        chk("to_count", gpu_data, 32'(4 * n));
        for (int i = 0; i < n; i++) begin
            step();
            chk("to_data", gpu_data, wq[i]);
            chk("to_data_instr", gpu_instr, 32'd0);
            chk("to_data_done", 32'(done), 32'd0);
            if (i == abort_at) begin
                #2;
                rst = 1'b1;
                #1;
                chk("rst_gpu_data", gpu_data, 32'd0);
                chk("rst_gpu_instr", gpu_instr, 32'd0);
                chk("rst_req_ready", 32'(req_ready), 32'd0);
                repeat (2) begin
                    step();
                    chk("rst_no_done", 32'(done), 32'd0);
                    chk("rst_no_err", 32'(err), 32'd0);
                    chk("rst_gpu_data_hold", gpu_data, 32'd0);
                end
                rst = 1'b0;
                step();
                chk("rst_ready_back", 32'(req_ready), 32'd1);
                chk("rst_done_after", 32'(done), 32'd0);
                return;
            end
        end
        step();
        chk("to_done", 32'(done), 32'd1);
        chk("to_done_err", 32'(err), 32'd0);
        chk("to_done_data", gpu_data, 32'd0);
        chk("to_done_ready", 32'(req_ready), 32'd0);
        step();
        chk("to_done_end", 32'(done), 32'd0);
        chk("to_ready_back", 32'(req_ready), 32'd1);
    endtask

    // Download of cnt bytes; gap_fixed < 0 picks random idle cycles between acks.
    task automatic do_copy_from(input logic [31:0] addr, input logic [31:0] cnt, input int gap_fixed);
        int n;
        int g;
        logic [31:0] d;
        n = int'(cnt >> 2);
        issue(2'd2, addr, cnt);
        chk("from_instr", gpu_instr, 32'd2);
        chk("from_wr_ready", 32'(wr_ready), 32'd0);
        step();
        chk("from_addr", gpu_data, addr);
        chk("from_addr_instr", gpu_instr, 32'd0);
        step();
        chk("from_count", gpu_data, cnt);
        step();
        g = (gap_fixed >= 0) ? gap_fixed : int'($urandom_range(0, 6));
        repeat (g) begin
            step();
            chk("from_gap_rd_valid", 32'(rd_valid), 32'd0);
        end
        for (int i = 0; i < n; i++) begin
            d            = $urandom;
            gpu_out_ack  = 1'b1;
            gpu_out_data = d;
            step();
            gpu_out_ack  = 1'b0;
            gpu_out_data = 32'd0;
            chk("from_rd_valid", 32'(rd_valid), 32'd1);
            chk("from_rd_data", rd_data, d);
            chk("from_done", 32'(done), 32'(i == n - 1));
            chk("from_err", 32'(err), 32'd0);
            if (i != n - 1) begin
                g = (gap_fixed >= 0) ? gap_fixed : int'($urandom_range(0, 6));
                repeat (g) begin
                    step();
                    chk("from_gap_rd_valid", 32'(rd_valid), 32'd0);
                    chk("from_gap_done", 32'(done), 32'd0);
                end
            end
        end
        chk("from_done_ready", 32'(req_ready), 32'd0);
        step();
        chk("from_ready_back", 32'(req_ready), 32'd1);
        chk("from_done_end", 32'(done), 32'd0);
        chk("from_rd_valid_end", 32'(rd_valid), 32'd0);
    endtask

    task automatic do_timeout();
        int k;
        issue(2'd2, 32'h0000_0080, 32'd8);
        step();
        step();
        step();
        gpu_out_ack  = 1'b1;
        gpu_out_data = 32'h5A5A_0001;
        step();
        gpu_out_ack  = 1'b0;
        gpu_out_data = 32'd0;
        chk("tmo_first_rd", 32'(rd_valid), 32'd1);
        k = 1;
        while (err !== 1'b1 && k < ACK_TIMEOUT + 10) begin
            chk("tmo_no_done", 32'(done), 32'd0);
            step();
            k++;
        end
        chk("tmo_latency", 32'(k), 32'(ACK_TIMEOUT));
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_ready_low", 32'(req_ready), 32'd0);
        step();
        chk("tmo_ready_back", 32'(req_ready), 32'd1);
        gpu_out_ack  = 1'b1;
        gpu_out_data = 32'h0000_0077;
        step();
        gpu_out_ack  = 1'b0;
        gpu_out_data = 32'd0;
        chk("tmo_late_ack", 32'(rd_valid), 32'd0);
        step();
        chk("tmo_late_ack2", 32'(rd_valid), 32'd0);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] cnt;
        logic        bad;
        int          mode;
        n_chk        = 0;
        n_fail       = 0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_op       = 2'd0;
        req_addr     = 32'd0;
        req_count    = 32'd0;
        wr_valid     = 1'b0;
        wr_data      = 32'd0;
        gpu_out_data = 32'd0;
        gpu_out_ack  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_wr_ready", 32'(wr_ready), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_rd_data", rd_data, 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_gpu_instr", gpu_instr, 32'd0);
        chk("reset_gpu_data", gpu_data, 32'd0);
        rst = 1'b0;
        step();
        chk("post_reset_ready", 32'(req_ready), 32'd1);
        chk("post_reset_instr", gpu_instr, 32'd0);

        // Directed upload with write gaps.
        wq = '{32'h0000_000A, 32'h0000_000B, 32'h0000_000C};
        do_copy_to(32'h0000_0100, 50, -1);

        // Directed download, acks three cycles apart.
        do_copy_from(32'h0000_0040, 32'd8, 2);

        // Directed rejects.
        do_reject(2'd1, 32'd0);
        do_reject(2'd2, 32'd6);
        do_reject(2'd3, 32'd8);
        do_reject(2'd1, 32'(4 * BUF_WORDS + 4));

        // Largest legal upload.
        wq.delete();
        for (int i = 0; i < BUF_WORDS; i++) wq.push_back($urandom);
        do_copy_to(32'hDEAD_0000, 20, -1);

        do_timeout();

        // Reset while the second of four words is on the wires, then recover.
        wq = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        do_copy_to(32'h0000_0200, 0, 1);
        wq = '{32'h5555_5555, 32'h6666_6666};
        do_copy_to(32'h0000_0300, 30, -1);

        // Randomized command mix classified by the acceptance rules.
        for (int it = 0; it < 40; it++) begin
            op   = 2'($urandom_range(0, 3));
            mode = int'($urandom_range(0, 5));
            if (mode == 0)      cnt = 32'd0;
            else if (mode == 1) cnt = 32'($urandom_range(1, 80));
            else                cnt = 32'(4 * $urandom_range(1, BUF_WORDS + 2));
            bad = (op != 2'd1 && op != 2'd2) || (cnt == 32'd0) || (cnt % 4 != 0) ||
                  (op == 2'd1 && cnt > 32'(4 * BUF_WORDS));
            if (bad) begin
                do_reject(op, cnt);
            end else if (op == 2'd1) begin
                wq.delete();
                for (int i = 0; i < int'(cnt / 4); i++) wq.push_back($urandom);
                do_copy_to($urandom, int'($urandom_range(0, 60)), -1);
            end else begin
                do_copy_from($urandom, cnt, -1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
